// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS write-back select, 32x32 register file with two read ports, retired-write counter.
// Optional REGFILE_BYPASS_EN: write-through bypass of a pending commit onto the read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbRegWrite,
  input  logic              wbMemtoReg,
  input  logic [DATA_W-1:0] wbReadData,
  input  logic [DATA_W-1:0] wbAddress,
  input  logic [AW-1:0]     wbWriteReg,
  input  logic [AW-1:0]     readReg1,
  input  logic [AW-1:0]     readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] wbData,
  output logic              wbCommit,
  output logic [CNT_W-1:0]  retireCount
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              commit;

  assign wbData = wbMemtoReg ? wbReadData : wbAddress;
  // r0 is hardwired, so a write to it is neither stored nor counted
  assign commit = wbRegWrite && (wbWriteReg != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wbCommit    <= 1'b0;
      retireCount <= '0;
    end else begin
      wbCommit <= commit;
      if (commit) begin
        regs[wbWriteReg] <= wbData;
        retireCount      <= retireCount + CNT_W'(1);
      end
    end
  end

  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (readReg1 != '0) readData1 = regs[readReg1];
    if (readReg2 != '0) readData2 = regs[readReg2];
`ifdef REGFILE_BYPASS_EN
    // reset wins over the bypass so reads reflect the cleared file
    if (commit && !reset && (readReg1 == wbWriteReg)) readData1 = wbData;
    if (commit && !reset && (readReg2 == wbWriteReg)) readData2 = wbData;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile (counter built at CNT_W=4 to reach wrap).
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbRegWrite, wbMemtoReg;
  logic [31:0] wbReadData, wbAddress;
  logic [4:0]  wbWriteReg, readReg1, readReg2;
  logic [31:0] readData1, readData2, wbData;
  logic        wbCommit;
  logic [3:0]  retireCount;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(4)) dut (
    .clk(clk), .reset(rst),
    .wbRegWrite(wbRegWrite), .wbMemtoReg(wbMemtoReg),
    .wbReadData(wbReadData), .wbAddress(wbAddress), .wbWriteReg(wbWriteReg),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2),
    .wbData(wbData), .wbCommit(wbCommit), .retireCount(retireCount)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m [32];
  logic [3:0]  mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty got=%h want=<none>", got);
    end else begin
      e = sb.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] rexp(input logic [4:0] a, input logic c,
                                       input logic [4:0] rd, input logic [31:0] d);
    if (a == 0 || rst) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (c && a == rd) return d;
`endif
    return m[a];
  endfunction

  // one MEM/WB entry: checks before the edge, expected post-edge state queued
  task automatic wb(input logic we, input logic m2r, input logic [4:0] rd,
                    input logic [31:0] ld, input logic [31:0] alu,
                    input logic [4:0] ra, input logic [4:0] rb);
    logic [31:0] d;
    logic        c;
    wbRegWrite = we;  wbMemtoReg = m2r; wbWriteReg = rd;
    wbReadData = ld;  wbAddress = alu;  readReg1 = ra; readReg2 = rb;
    d = m2r ? ld : alu;
    c = we && (rd != 0) && !rst;
    #1;
    chk("wbdata", wbData, d);
    chk("rd1_pre", readData1, rexp(ra, c, rd, d));
    chk("rd2_pre", readData2, rexp(rb, c, rd, d));
    if (c) begin
      m[rd] = d;
      mcnt  = mcnt + 4'd1;
    end
    push("commit", {31'b0, c});
    push("retire", {28'b0, mcnt});
    push("rd1_post", (ra == 0 || rst) ? 32'h0 : m[ra]);
    push("rd2_post", (rb == 0 || rst) ? 32'h0 : m[rb]);
    @(posedge clk);
    #1;
    pop({31'b0, wbCommit});
    pop({28'b0, retireCount});
    pop(readData1);
    pop(readData2);
    wbRegWrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wbRegWrite = 0; wbMemtoReg = 0; wbReadData = 0; wbAddress = 0;
    wbWriteReg = 0; readReg1 = 5'd7; readReg2 = 5'd0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    mcnt = 4'd0;
    #1;
    chk("rst_rd1", readData1, 32'h0);
    chk("rst_commit", {31'b0, wbCommit}, 32'h0);
    chk("rst_retire", {28'b0, retireCount}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    wb(1, 0, 5'd5, 32'h0, 32'h1234, 5'd5, 5'd5);
    wb(1, 1, 5'd6, 32'h77, 32'h0, 5'd5, 5'd6);
    // asynchronous reset mid-cycle, no clock edge in between
    readReg1 = 5'd5;
    #1;
    chk("r5_before_rst", readData1, 32'h1234);
    rst = 1'b1;
    #1;
    chk("r5_async_rst", readData1, 32'h0);
    chk("retire_async_rst", {28'b0, retireCount}, 32'h0);
    chk("commit_async_rst", {31'b0, wbCommit}, 32'h0);
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    mcnt = 4'd0;
    wb(1, 0, 5'd9, 32'h0, 32'hAAAA, 5'd9, 5'd6);
    rst = 1'b0;

    wb(1, 1, 5'd8, 32'hDEADBEEF, 32'h11, 5'd8, 5'd1);
    chk("r8_load", readData1, 32'hDEADBEEF);
    wb(1, 0, 5'd8, 32'hDEADBEEF, 32'h11, 5'd8, 5'd8);
    chk("r8_alu", readData2, 32'h00000011);
    wb(1, 0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd8);
    chk("r0_commit", {31'b0, wbCommit}, 32'h0);
    chk("r0_read", readData1, 32'h0);
    wb(1, 0, 5'd3, 32'h0, 32'hA, 5'd3, 5'd0);
    wb(1, 0, 5'd3, 32'h0, 32'hB, 5'd3, 5'd3);
    chk("r3_after", readData1, 32'hB);
    wb(0, 0, 5'd9, 32'h0, 32'h55, 5'd9, 5'd3);
    chk("r9_nowrite", readData1, 32'h0);

    for (int n = 0; n < 40 && mcnt != 4'd15; n++)
      wb(1, $urandom_range(0, 1), 5'($urandom_range(1, 31)), $urandom, $urandom,
         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    chk("retire_max", {28'b0, retireCount}, 32'd15);
    wb(1, 0, 5'd12, 32'h0, 32'hC0FFEE, 5'd12, 5'd8);
    chk("retire_wrap", {28'b0, retireCount}, 32'd0);
    chk("wrap_commit", {31'b0, wbCommit}, 32'd1);

    for (int n = 0; n < 12; n++)
      wb($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
         $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
